// File: rtl/atr_state_gen.sv
// ATR state generator: turns raw run_tx/run_rx levels into delayed, registered
// atr_tx/atr_rx bits with programmable turn-on delay, turn-off hold and a force override.
module atr_state_gen #(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        run_tx,
    input  logic        run_rx,
    output logic        atr_tx,
    output logic        atr_rx,
    output logic [7:0]  status
);

    localparam logic [7:0] ADDR_TX    = BASE;
    localparam logic [7:0] ADDR_RX    = BASE + 8'd1;
    localparam logic [7:0] ADDR_FORCE = BASE + 8'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ON_WAIT  = 2'd1,
        ACTIVE   = 2'd2,
        OFF_WAIT = 2'd3
    } state_t;

    // Index 0 is the TX direction, index 1 is RX, throughout.
    logic [15:0] on_dly_reg  [2];
    logic [15:0] off_dly_reg [2];
    logic        force_en_reg;
    logic [1:0]  force_val_reg;
    logic [1:0]  run;
    logic [1:0]  atr_bus;
    logic [3:0]  state_bus;

    assign run = {run_rx, run_tx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_dly_reg[0]  <= '0;
            off_dly_reg[0] <= '0;
            on_dly_reg[1]  <= '0;
            off_dly_reg[1] <= '0;
            force_en_reg   <= 1'b0;
            force_val_reg  <= 2'b00;
        end else if (set_stb) begin
            if (set_addr == ADDR_TX) begin
                on_dly_reg[0]  <= set_data[15:0];
                off_dly_reg[0] <= set_data[31:16];
            end
            if (set_addr == ADDR_RX) begin
                on_dly_reg[1]  <= set_data[15:0];
                off_dly_reg[1] <= set_data[31:16];
            end
            if (set_addr == ADDR_FORCE) begin
                force_en_reg  <= set_data[0];
                force_val_reg <= {set_data[1], set_data[2]};
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
        state_t      state_reg;
        state_t      state_next;
        logic [15:0] cnt_reg;
        logic [15:0] cnt_next;
        logic        atr_reg;

        // Counter is only loaded on entry to a wait state, so delay rewrites
        // mid-count take effect at the next entry.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            if (force_en_reg) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (run[gi]) begin
                            if (on_dly_reg[gi] == 16'd0) begin
                                state_next = ACTIVE;
                            end else begin
                                cnt_next   = on_dly_reg[gi] - 16'd1;
                                state_next = ON_WAIT;
                            end
                        end
                    end
                    ON_WAIT: begin
                        if (!run[gi]) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == 16'd0) begin
                            state_next = ACTIVE;
                        end else begin
                            cnt_next = cnt_reg - 16'd1;
                        end
                    end
                    ACTIVE: begin
                        if (!run[gi]) begin
                            if (off_dly_reg[gi] == 16'd0) begin
                                state_next = IDLE;
                            end else begin
                                cnt_next   = off_dly_reg[gi] - 16'd1;
                                state_next = OFF_WAIT;
                            end
                        end
                    end
                    OFF_WAIT: begin
                        if (run[gi]) begin
                            state_next = ACTIVE;
                            cnt_next   = '0;
                        end else if (cnt_reg == 16'd0) begin
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_reg - 16'd1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                atr_reg   <= 1'b0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                atr_reg   <= force_en_reg ? force_val_reg[gi]
                                          : (state_next == ACTIVE || state_next == OFF_WAIT);
            end
        end

        assign atr_bus[gi]          = atr_reg;
        assign state_bus[gi*2 +: 2] = state_next;
    end

    // Built from next-state values so status moves on the same edge as atr_*.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status <= 8'h00;
        end else begin
            status <= {2'b00, force_en_reg, state_bus[3:2], state_bus[1:0], 1'b0};
        end
    end

    assign atr_tx = atr_bus[0];
    assign atr_rx = atr_bus[1];

endmodule

// File: tb/tb_atr_state_gen.sv
// Scoreboard bench for atr_state_gen: a streak-counting reference model predicts
// atr_tx/atr_rx/status each cycle; a monitor pops and compares after every edge.
module tb_atr_state_gen;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'h00;
    logic [31:0] set_data = 32'h0;
    logic        run_tx = 1'b0;
    logic        run_rx = 1'b0;
    logic        atr_tx;
    logic        atr_rx;
    logic [7:0]  status;

    atr_state_gen #(.BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .run_tx   (run_tx),
        .run_rx   (run_rx),
        .atr_tx   (atr_tx),
        .atr_rx   (atr_rx),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = TX, 1 = RX.
    int   m_on [2];
    int   m_off [2];
    bit   m_fen;
    bit   m_fv [2];
    bit   m_act [2];
    int   m_streak [2];
    int   m_target [2];

    int         checks = 0;
    int         passed = 0;
    logic [9:0] exp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_fen = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_on[d] = 0; m_off[d] = 0; m_fv[d] = 1'b0;
            m_act[d] = 1'b0; m_streak[d] = 0; m_target[d] = 0;
        end
    endtask

    // One clock of stimulus: drive at negedge, predict the post-edge outputs.
    task automatic step(input logic rtx, input logic rrx, input logic stb,
                        input logic [7:0] addr, input logic [31:0] data);
        logic [1:0] r;
        logic [1:0] o;
        logic [1:0] st [2];
        @(negedge clk);
        run_tx = rtx; run_rx = rrx; set_stb = stb; set_addr = addr; set_data = data;
        r = {rrx, rtx};
        for (int d = 0; d < 2; d++) begin
            if (m_fen) begin
                m_act[d] = 1'b0; m_streak[d] = 0;
                o[d] = m_fv[d]; st[d] = 2'd0;
            end else begin
                // A delay of D means the (D+1)th consecutive sample flips the output;
                // D is captured at the first sample of the streak.
                if (r[d] != m_act[d]) begin
                    if (m_streak[d] == 0) m_target[d] = m_act[d] ? m_off[d] : m_on[d];
                    m_streak[d]++;
                    if (m_streak[d] == m_target[d] + 1) begin
                        m_act[d] = ~m_act[d];
                        m_streak[d] = 0;
                    end
                end else begin
                    m_streak[d] = 0;
                end
                o[d] = m_act[d];
                st[d] = m_act[d] ? (m_streak[d] != 0 ? 2'd3 : 2'd2)
                                 : (m_streak[d] != 0 ? 2'd1 : 2'd0);
            end
        end
        exp_q.push_back({o[0], o[1], 2'b00, m_fen, st[1], st[0], 1'b0});
        if (stb) begin
            $display("write addr=%h data=%h run_tx=%0b run_rx=%0b at %0t", addr, data, rtx, rrx, $time);
            if (addr == BASE) begin
                m_on[0] = int'(data[15:0]); m_off[0] = int'(data[31:16]);
            end else if (addr == BASE + 8'd1) begin
                m_on[1] = int'(data[15:0]); m_off[1] = int'(data[31:16]);
            end else if (addr == BASE + 8'd2) begin
                m_fen = data[0]; m_fv[1] = data[1]; m_fv[0] = data[2];
            end
        end
    endtask

    task automatic run_for(input int n, input logic rtx, input logic rrx);
        for (int i = 0; i < n; i++) step(rtx, rrx, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic rtx, input logic rrx);
        step(rtx, rrx, 1'b1, addr, data);
    endtask

    // Monitor: outputs are presented every cycle, compared just after the edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("atr", {6'b0, atr_tx, atr_rx}, {6'b0, e[9:8]});
                check("status", status, e[7:0]);
            end
        end
    end

    initial begin
        logic rt;
        logic rr;
        logic [7:0]  a;
        logic [31:0] dat;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_atr", {6'b0, atr_tx, atr_rx}, 8'h00);
        check("reset_status", status, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Basic TX burst with on=3, off=5.
        wr(BASE, {16'd5, 16'd3}, 1'b0, 1'b0);
        run_for(9, 1'b0, 1'b0);
        run_for(20, 1'b1, 1'b0);
        run_for(15, 1'b0, 1'b0);

        // Zero delays, one-cycle RX pulse.
        wr(BASE, 32'h0, 1'b0, 1'b0);
        wr(BASE + 8'd1, 32'h0, 1'b0, 1'b0);
        run_for(3, 1'b0, 1'b0);
        run_for(1, 1'b0, 1'b1);
        run_for(4, 1'b0, 1'b0);

        // Abort during ON_WAIT, then re-trigger during OFF_WAIT.
        wr(BASE, {16'd10, 16'd10}, 1'b0, 1'b0);
        run_for(4, 1'b1, 1'b0);
        run_for(6, 1'b0, 1'b0);
        run_for(15, 1'b1, 1'b0);
        run_for(3, 1'b0, 1'b0);
        run_for(5, 1'b1, 1'b0);
        run_for(14, 1'b0, 1'b0);

        // Force mode while RX is running, then release with rx_on=2.
        wr(BASE + 8'd1, {16'd0, 16'd2}, 1'b0, 1'b1);
        run_for(5, 1'b0, 1'b1);
        wr(BASE + 8'd2, 32'h5, 1'b0, 1'b1);
        run_for(4, 1'b0, 1'b1);
        wr(BASE + 8'd2, 32'h0, 1'b0, 1'b1);
        run_for(8, 1'b0, 1'b1);
        run_for(4, 1'b0, 1'b0);

        // Randomised run levels and settings writes, including stray addresses.
        rt = 1'b0; rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rt = ~rt;
            if ($urandom_range(0, 5) == 0) rr = ~rr;
            if ($urandom_range(0, 11) == 0) begin
                a = BASE + 8'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    a = 8'($urandom_range(0, 255));
                    if (a >= BASE && a <= BASE + 8'd2) a = BASE + 8'd3;
                end
                if (a == BASE + 8'd2) dat = {29'd0, 3'($urandom_range(0, 7))};
                else dat = {16'($urandom_range(0, 6)), 16'($urandom_range(0, 6))};
                wr(a, dat, rt, rr);
            end else begin
                step(rt, rr, 1'b0, 8'h00, 32'h0);
            end
        end
        wr(BASE + 8'd2, 32'h0, 1'b0, 1'b0);
        wr(BASE + 8'd1, 32'h0, 1'b0, 1'b0);
        run_for(20, 1'b0, 1'b0);

        // Maximum on-delay, then asynchronous reset in the middle of OFF_WAIT.
        wr(BASE, {16'd20, 16'hFFFF}, 1'b0, 1'b0);
        run_for(65540, 1'b1, 1'b0);
        run_for(6, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_atr_tx", {7'b0, atr_tx}, 8'h01);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_atr", {6'b0, atr_tx, atr_rx}, 8'h00);
        check("async_reset_status", status, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_for(3, 1'b1, 1'b0);
        run_for(3, 1'b0, 1'b0);
        run_for(2, 1'b1, 1'b1);
        run_for(2, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
